// File: rtl/cpu.sv
// Single-cycle 32-bit MIPS-subset processor: combinational fetch/decode/execute,
// with register file, data memory and PC all updated on the same rising edge.

module instruction_memory #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);
  // Program image is loaded from outside through hierarchy; zero words decode as NOPs.
  logic [31:0] ram [0:DEPTH-1] = '{default: '0};

  assign instr = ram[addr];
endmodule

module register_file (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];

  // r0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
endmodule

module data_memory #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);
  // Contents survive reset; only the time-zero image is cleared.
  logic [31:0] ram [0:DEPTH-1] = '{default: '0};

  always_ff @(posedge clock) begin
    if (we) ram[addr] <= wd;
  end

  assign rd = ram[addr];
endmodule

module cpu #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64
) (
  input logic clock,
  input logic reset,
  input logic start
);
  localparam int unsigned PC_W = $clog2(IMEM_DEPTH);
  localparam int unsigned DA_W = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] pc_next;
  logic [31:0]     instr;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] simm;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] ea;
  logic [31:0] dmem_rd;

  logic        reg_we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        mem_we;
  logic        taken;
  logic        unused_bits;

  instruction_memory #(.DEPTH(IMEM_DEPTH)) instruction_Memory (
    .addr  (pc),
    .instr (instr)
  );

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign simm   = {{16{instr[15]}}, instr[15:0]};

  register_file register_File (
    .clock (clock),
    .reset (reset),
    .we    (reg_we & start),
    .wa    (wa),
    .wd    (wd),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  // Word-indexed effective address shared by addi, lw and sw.
  assign ea = rs_val + simm;

  // Reset gating keeps a store from landing on the edge where reset aborts the instruction.
  data_memory #(.DEPTH(DMEM_DEPTH)) data_Memory (
    .clock (clock),
    .we    (mem_we & start & ~reset),
    .addr  (ea[DA_W-1:0]),
    .wd    (rt_val),
    .rd    (dmem_rd)
  );

  // Decode and execute; anything unrecognised falls through as a NOP.
  always_comb begin
    reg_we = 1'b0;
    wa     = rt;
    wd     = ea;
    mem_we = 1'b0;
    taken  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wa     = rd;
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  wd = rs_val + rt_val;
          FN_SUB:  wd = rs_val - rt_val;
          FN_AND:  wd = rs_val & rt_val;
          FN_OR:   wd = rs_val | rt_val;
          FN_SLT:  wd = {31'd0, ($signed(rs_val) < $signed(rt_val))};
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_we = 1'b1;
        wd     = ea;
      end
      OP_LW: begin
        reg_we = 1'b1;
        wd     = dmem_rd;
      end
      OP_SW:  mem_we = 1'b1;
      OP_BEQ: taken  = (rs_val == rt_val);
      default: ;
    endcase
  end

  // Branch offsets are in words; truncation to PC width gives the modulo-depth wrap.
  assign pc_plus1 = pc + PC_W'(1);
  assign pc_next  = taken ? (pc_plus1 + simm[PC_W-1:0]) : pc_plus1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (start) begin
      pc <= pc_next;
    end
  end

  assign unused_bits = ^{instr[10:6], ea[31:DA_W]};
endmodule

// File: tb/tb_cpu.sv
// Directed bench for the single-cycle cpu: loads a program through hierarchy and
// checks registers, data memory and PC against hand-computed values.

module tb_cpu;
  logic clock;
  logic reset;
  logic start;

  int checks;
  int failures;

  cpu dut (
    .clock (clock),
    .reset (reset),
    .start (start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_addi(input int rt, input int rs, input int imm);
    return {6'b001000, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Advance n rising edges, returning on the following falling edge for sampling.
  task automatic run(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) dut.instruction_Memory.ram[i] = 32'd0;
  endtask

  logic [31:0] snap [0:31];

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b1;
    #1;

    clear_imem();
    dut.instruction_Memory.ram[0]  = enc_addi(1, 1, 9);
    dut.instruction_Memory.ram[1]  = enc_addi(2, 2, 15);
    dut.instruction_Memory.ram[2]  = enc_addi(3, 3, 25);
    dut.instruction_Memory.ram[3]  = enc_addi(4, 4, 29);
    dut.instruction_Memory.ram[4]  = enc_r(5, 1, 2, 6'b100000);
    dut.instruction_Memory.ram[5]  = enc_r(6, 2, 4, 6'b100100);
    dut.instruction_Memory.ram[6]  = enc_r(7, 1, 2, 6'b100101);
    dut.instruction_Memory.ram[7]  = enc_r(8, 3, 4, 6'b101010);
    dut.instruction_Memory.ram[8]  = enc_i(6'b101011, 3, 4, 9);
    dut.instruction_Memory.ram[9]  = enc_i(6'b100011, 9, 3, 13);
    dut.instruction_Memory.ram[10] = enc_i(6'b000100, 1, 6, 10);
    dut.instruction_Memory.ram[11] = enc_i(6'b000100, 9, 3, 10);
    dut.instruction_Memory.ram[18] = enc_addi(13, 0, 100);
    dut.instruction_Memory.ram[21] = enc_addi(10, 0, 100);
    dut.instruction_Memory.ram[22] = enc_addi(11, 0, 100);
    dut.instruction_Memory.ram[23] = enc_addi(12, 0, 100);
    dut.instruction_Memory.ram[24] = enc_addi(0, 0, 5);

    run(2);
    check("reset_pc", 32'(dut.pc), 32'd0);
    check("reset_r1", dut.register_File.regs[1], 32'd0);
    check("reset_dmem38", dut.data_Memory.ram[38], 32'd0);
    reset = 1'b0;

    run(8);
    check("addi_r1", dut.register_File.regs[1], 32'd9);
    check("addi_r2", dut.register_File.regs[2], 32'd15);
    check("addi_r3", dut.register_File.regs[3], 32'd25);
    check("addi_r4", dut.register_File.regs[4], 32'd29);
    check("add_r5",  dut.register_File.regs[5], 32'd24);
    check("and_r6",  dut.register_File.regs[6], 32'd13);
    check("or_r7",   dut.register_File.regs[7], 32'd15);
    check("slt_r8",  dut.register_File.regs[8], 32'd1);
    check("pc_after_alu", 32'(dut.pc), 32'd8);

    run(1);
    check("sw_dmem38", dut.data_Memory.ram[38], 32'd25);
    run(1);
    check("lw_r9", dut.register_File.regs[9], 32'd25);
    run(1);
    check("beq_not_taken_pc", 32'(dut.pc), 32'd11);
    run(1);
    check("beq_taken_pc", 32'(dut.pc), 32'd22);

    run(28);
    check("pc_after_40", 32'(dut.pc), 32'd50);
    check("skip_r10", dut.register_File.regs[10], 32'd0);
    check("target_r11", dut.register_File.regs[11], 32'd100);
    check("target_r12", dut.register_File.regs[12], 32'd100);
    check("skip_r13", dut.register_File.regs[13], 32'd0);
    check("r0_zero", dut.register_File.regs[0], 32'd0);

    for (int i = 0; i < 32; i++) snap[i] = dut.register_File.regs[i];
    start = 1'b0;
    run(5);
    check("stall_pc", 32'(dut.pc), 32'd50);
    for (int i = 0; i < 32; i++) check($sformatf("stall_r%0d", i), dut.register_File.regs[i], snap[i]);
    check("stall_dmem38", dut.data_Memory.ram[38], 32'd25);
    start = 1'b1;
    run(3);
    check("resume_pc", 32'(dut.pc), 32'd53);

    // Asynchronous reset pulse between edges.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_pc", 32'(dut.pc), 32'd0);
    check("async_reset_r3", dut.register_File.regs[3], 32'd0);
    check("async_reset_r11", dut.register_File.regs[11], 32'd0);
    check("reset_keeps_dmem38", dut.data_Memory.ram[38], 32'd25);

    // All-zero program: NOPs only, PC wraps modulo 64.
    clear_imem();
    @(negedge clock);
    reset = 1'b0;
    run(63);
    check("nop_pc63", 32'(dut.pc), 32'd63);
    run(1);
    check("wrap_pc0", 32'(dut.pc), 32'd0);
    run(1);
    check("wrap_pc1", 32'(dut.pc), 32'd1);
    check("nop_r1", dut.register_File.regs[1], 32'd0);
    check("nop_dmem38", dut.data_Memory.ram[38], 32'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
